// File: rtl/spi_server_if.sv
// Host-side command, write-stream and read-stream signals of the SPI master.
// master = host/test harness side, slave = spi_server side.
interface spi_server_if #(
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int CODE_BIT_WIDTH          = 4,
  parameter int START_ADDRESS_BIT_WIDTH = 16
);
  localparam int NumTransactionsBitWidth =
    MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1;

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic                               cmd_read;
  logic [CODE_BIT_WIDTH-1:0]          cmd_code;
  logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_start_address;
  logic [NumTransactionsBitWidth-1:0] cmd_num_transactions;
  logic [MESSAGE_BIT_WIDTH-1:0]       wr_data;
  logic                               wr_data_valid;
  logic                               wr_data_ready;
  logic [MESSAGE_BIT_WIDTH-1:0]       rd_data;
  logic                               rd_data_valid;
  logic                               busy;
  logic                               done;

  modport master (
    output cmd_valid, cmd_read, cmd_code, cmd_start_address, cmd_num_transactions,
    output wr_data, wr_data_valid,
    input  cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_code, cmd_start_address, cmd_num_transactions,
    input  wr_data, wr_data_valid,
    output cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy, done
  );
endinterface

// File: rtl/spi_server.sv
// SPI master: sends an instruction word, then streams N write words out or
// captures N read words from MISO. SCK idles low; every bit ends on a fall.
module spi_server #(
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int CODE_BIT_WIDTH          = 4,
  parameter int START_ADDRESS_BIT_WIDTH = 16,
  parameter int CLK_DIV                 = 2,
  parameter int READ_GAP_CYCLES         = 8
) (
  input  logic       clk,
  input  logic       rst,
  spi_server_if.slave bus,
  input  logic       client_idle,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO
);
  localparam int NumTransactionsBitWidth =
    MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1;
  localparam int BitCntW = $clog2(MESSAGE_BIT_WIDTH);
  localparam int CntW    = $clog2(CLK_DIV + READ_GAP_CYCLES + 1);

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(MESSAGE_BIT_WIDTH - 1);
  localparam logic [BitCntW-1:0] BitOne  = BitCntW'(1);
  localparam logic [CntW-1:0]    DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]    GapLast = CntW'(READ_GAP_CYCLES - 1);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);
  localparam logic [NumTransactionsBitWidth-1:0] WordOne = NumTransactionsBitWidth'(1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, NEXT, FETCH, GAP, DONE} state_t;

  state_t                             state;
  state_t                             state_nxt;
  logic [CntW-1:0]                    cnt;
  logic [BitCntW-1:0]                 bit_cnt;
  logic [NumTransactionsBitWidth-1:0] words_left;
  logic [NumTransactionsBitWidth-1:0] words_rem;
  logic [MESSAGE_BIT_WIDTH-1:0]       tx_sr;
  logic [MESSAGE_BIT_WIDTH-1:0]       rx_sr;
  logic [MESSAGE_BIT_WIDTH-1:0]       rd_data_r;
  logic                               is_read;
  logic                               in_instr;
  logic                               idle_s1;
  logic                               idle_s2;
  logic                               sck_r;
  logic                               done_r;
  logic                               rd_valid_r;
  logic                               cmd_hs;
  logic                               wr_hs;
  logic                               bit_end;
  logic                               rd_word_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_hs    = 1'b0;
    wr_hs     = 1'b0;
    bit_end   = 1'b0;
    // words_left only counts down after data words, never after the instruction
    words_rem = in_instr ? words_left : words_left - WordOne;
    case (state)
      IDLE:  if (bus.cmd_valid && idle_s2) begin
               cmd_hs    = 1'b1;
               state_nxt = LOW;
             end
      LOW:   if (cnt == DivLast) state_nxt = HIGH;
      HIGH:  if (cnt == DivLast) begin
               bit_end   = 1'b1;
               state_nxt = (bit_cnt == LastBit) ? NEXT : LOW;
             end
      NEXT:  if (words_rem == '0) state_nxt = DONE;
             else if (is_read)     state_nxt = GAP;
             else                  state_nxt = FETCH;
      FETCH: if (bus.wr_data_valid) begin
               wr_hs     = 1'b1;
               state_nxt = LOW;
             end
      GAP:   if (cnt == GapLast) state_nxt = LOW;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_word_end = (state == NEXT) && is_read && !in_instr;

  // Control: phase counting, SCK, framing counters, output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_s1    <= 1'b0;
      idle_s2    <= 1'b0;
      sck_r      <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      in_instr   <= 1'b0;
      is_read    <= 1'b0;
    end else begin
      idle_s1    <= client_idle;
      idle_s2    <= idle_s1;
      sck_r      <= (state_nxt == HIGH);
      done_r     <= (state == DONE);
      rd_valid_r <= rd_word_end;
      if (rd_word_end) rd_data_r <= rx_sr;
      cnt <= (state_nxt != state) ? '0 : cnt + CntOne;
      if (cmd_hs) begin
        bit_cnt    <= '0;
        words_left <= bus.cmd_num_transactions;
        in_instr   <= 1'b1;
        is_read    <= bus.cmd_read;
      end else begin
        if (bit_end) bit_cnt <= bit_cnt + BitOne;
        if (state == NEXT) begin
          words_left <= words_rem;
          in_instr   <= 1'b0;
        end
      end
    end
  end

  // Data: shift registers; MISO is taken on the same edge that drops SCK
  always_ff @(posedge clk) begin
    if (cmd_hs)
      tx_sr <= {bus.cmd_read, bus.cmd_code, bus.cmd_start_address, bus.cmd_num_transactions};
    else if (wr_hs)
      tx_sr <= bus.wr_data;
    else if (bit_end)
      tx_sr <= {tx_sr[MESSAGE_BIT_WIDTH-2:0], 1'b0};
    if (bit_end)
      rx_sr <= {rx_sr[MESSAGE_BIT_WIDTH-2:0], MISO};
  end

  assign SCK  = sck_r;
  assign MOSI = ((state == LOW) || (state == HIGH)) && (in_instr || !is_read) &&
                tx_sr[MESSAGE_BIT_WIDTH-1];

  assign bus.cmd_ready     = (state == IDLE) && idle_s2;
  assign bus.wr_data_ready = (state == FETCH);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_r;
  assign bus.rd_data       = rd_data_r;
  assign bus.rd_data_valid = rd_valid_r;
endmodule

// File: tb/tb_spi_server.sv
// Scoreboard bench for spi_server with a behavioural SPI client model.
module tb_spi_server;
  localparam int MW = 32;
  localparam int CW = 4;
  localparam int AW = 16;
  localparam int CLK_DIV = 2;
  localparam int RGC = 8;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst;
  logic client_idle;
  logic SCK;
  logic MOSI;
  logic MISO;

  spi_server_if #(.MESSAGE_BIT_WIDTH(MW), .CODE_BIT_WIDTH(CW),
                  .START_ADDRESS_BIT_WIDTH(AW)) bus ();

  spi_server #(.MESSAGE_BIT_WIDTH(MW), .CODE_BIT_WIDTH(CW), .START_ADDRESS_BIT_WIDTH(AW),
               .CLK_DIV(CLK_DIV), .READ_GAP_CYCLES(RGC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .client_idle(client_idle),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rises = 0;
  int dones = 0;
  int wr_ready_cycles = 0;
  int fetch_sck_high = 0;
  int mosi_err = 0;
  int last_fall = 0;
  bit client_rst = 1'b0;

  logic [31:0] exp_word[$];
  logic [15:0] exp_waddr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_q[$];

  int          c_bits = 0;
  int          c_words = 0;
  int          c_n = 0;
  logic [31:0] c_sr = '0;
  logic [31:0] miso_sr = '0;
  logic [15:0] c_addr = '0;
  bit          c_read = 1'b0;
  logic        sck_d = 1'b0;
  logic        mosi_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI client model: samples MOSI on SCK rise, updates MISO after SCK fall
  initial begin
    MISO = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (client_rst) begin
        c_bits = 0; c_words = 0; c_sr = '0; miso_sr = '0; MISO = 1'b0;
      end else if (SCK && !sck_d) begin
        rises++;
        if (c_words > 0 && c_read && c_bits == 0)
          check("read_gap_cycles", cyc - last_fall, 1 + RGC + CLK_DIV);
        if (c_words > 0 && c_read && MOSI) mosi_err++;
        c_sr = {c_sr[30:0], MOSI};
        c_bits++;
      end else if (!SCK && sck_d) begin
        last_fall = cyc;
        if (c_bits == 32) begin
          c_bits = 0;
          if (c_words == 0) begin
            if (exp_word.size() > 0) check("instr_word", c_sr, exp_word.pop_front());
            else fail_now("instr_word_unexpected");
            c_read = c_sr[31];
            c_addr = c_sr[26:11];
            c_n    = int'(c_sr[10:0]);
            if (c_read && c_n > 0) miso_sr = {16'h0, c_addr} ^ KEY;
            c_words = (c_n == 0) ? 0 : 1;
          end else begin
            if (!c_read) begin
              if (exp_word.size() > 0) check("write_word", c_sr, exp_word.pop_front());
              else fail_now("write_word_unexpected");
              if (exp_waddr.size() > 0) check("write_addr", {16'h0, c_addr}, {16'h0, exp_waddr.pop_front()});
              else fail_now("write_addr_unexpected");
            end
            c_addr = c_addr + 16'd1;
            if (c_words == c_n) c_words = 0;
            else begin
              c_words++;
              if (c_read) miso_sr = {16'h0, c_addr} ^ KEY;
            end
          end
        end else begin
          miso_sr = miso_sr << 1;
        end
        MISO = miso_sr[31];
      end
      if (SCK && sck_d && (MOSI !== mosi_d)) mosi_err++;
      sck_d  = SCK;
      mosi_d = MOSI;
    end
  end

  // Monitor: read words, done pulses, fetch behaviour
  initial forever begin
    @(posedge clk); #1;
    if (bus.rd_data_valid) begin
      check("rd_valid_latency", cyc - last_fall, 1);
      if (exp_rd.size() > 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
      else fail_now("rd_data_unexpected");
    end
    if (bus.done) begin
      dones++;
      check("done_latency", cyc - last_fall, 2);
    end
    if (bus.wr_data_ready) begin
      wr_ready_cycles++;
      if (SCK) fetch_sck_high++;
    end
  end

  // Write word source
  initial begin
    bit hs;
    hs = 1'b0;
    bus.wr_data_valid = 1'b0;
    bus.wr_data = '0;
    forever begin
      @(posedge clk); #1;
      if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
      bus.wr_data_valid = (wr_q.size() > 0);
      bus.wr_data = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
      hs = bus.wr_data_valid && bus.wr_data_ready;
    end
  end

  task automatic reset_counts();
    rises = 0; dones = 0; wr_ready_cycles = 0; fetch_sck_high = 0; mosi_err = 0;
  endtask

  task automatic start_txn(input bit rd, input logic [3:0] code, input logic [15:0] addr,
                           input logic [10:0] n);
    int t;
    t = 0;
    bus.cmd_read = rd; bus.cmd_code = code;
    bus.cmd_start_address = addr; bus.cmd_num_transactions = n;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.cmd_ready) fail_now("cmd_ready_timeout");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (bus.busy && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (bus.busy) fail_now(name);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string name, input int exp_rises, input int exp_dones);
    check({name, "_rises"}, rises, exp_rises);
    check({name, "_dones"}, dones, exp_dones);
    check({name, "_mosi_err"}, mosi_err, 0);
    check({name, "_pending_words"}, exp_word.size() + exp_waddr.size() + exp_rd.size(), 0);
  endtask

  initial begin
    int t;
    int sck_hi;
    int seen_ready;
    rst = 1'b1; client_idle = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_code = '0;
    bus.cmd_start_address = '0; bus.cmd_num_transactions = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", SCK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_wr_ready", bus.wr_data_ready, 0);
    check("rst_rd_valid", bus.rd_data_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;

    // Write, data always available
    reset_counts();
    exp_word.push_back(32'h00008002); exp_word.push_back(32'hDEADBEEF); exp_word.push_back(32'h12345678);
    exp_waddr.push_back(16'h0010); exp_waddr.push_back(16'h0011);
    wr_q.push_back(32'hDEADBEEF); wr_q.push_back(32'h12345678);
    start_txn(1'b0, 4'd0, 16'h0010, 11'd2);
    wait_idle("write_timeout", 2000);
    end_checks("write", 96, 1);

    // Read of three words
    reset_counts();
    exp_word.push_back(32'h90080003);
    exp_rd.push_back(32'hA5A5A4A5); exp_rd.push_back(32'hA5A5A4A4); exp_rd.push_back(32'hA5A5A4A7);
    start_txn(1'b1, 4'd2, 16'h0100, 11'd3);
    wait_idle("read_timeout", 2000);
    end_checks("read", 128, 1);
    check("read_no_wr_ready", wr_ready_cycles, 0);

    // Write with a 50-cycle stall before the second data word
    reset_counts();
    exp_word.push_back(32'h08020002); exp_word.push_back(32'hCAFEF00D); exp_word.push_back(32'h0BADC0DE);
    exp_waddr.push_back(16'h0040); exp_waddr.push_back(16'h0041);
    wr_q.push_back(32'hCAFEF00D);
    start_txn(1'b0, 4'd1, 16'h0040, 11'd2);
    t = 0;
    while (wr_q.size() > 0 && t < 500) begin @(posedge clk); #1; t++; end
    while (!bus.wr_data_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!bus.wr_data_ready) fail_now("stall_fetch_timeout");
    repeat (50) @(posedge clk);
    #1;
    wr_q.push_back(32'h0BADC0DE);
    wait_idle("stall_timeout", 2000);
    end_checks("stall", 96, 1);
    check("stall_sck_during_fetch", fetch_sck_high, 0);
    check("stall_fetch_long", (wr_ready_cycles >= 51) ? 1 : 0, 1);

    // Instruction-only write
    reset_counts();
    exp_word.push_back(32'h1891A000);
    start_txn(1'b0, 4'd3, 16'h1234, 11'd0);
    wait_idle("n0_timeout", 1000);
    end_checks("n0", 32, 1);
    check("n0_no_wr_ready", wr_ready_cycles, 0);

    // Client not idle holds off the command
    reset_counts();
    client_idle = 1'b0;
    @(posedge clk); #1;
    check("idle_fall_lag1", bus.cmd_ready, 1);
    @(posedge clk); #1;
    check("idle_fall_lag2", bus.cmd_ready, 0);
    exp_word.push_back(32'h3FFFF801); exp_word.push_back(32'h55AA33CC);
    exp_waddr.push_back(16'hFFFF);
    wr_q.push_back(32'h55AA33CC);
    bus.cmd_read = 1'b0; bus.cmd_code = 4'd7;
    bus.cmd_start_address = 16'hFFFF; bus.cmd_num_transactions = 11'd1;
    bus.cmd_valid = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_ready || SCK || bus.busy) seen_ready++;
    end
    check("idle_hold_off", seen_ready, 0);
    client_idle = 1'b1;
    @(posedge clk); #1;
    check("idle_rise_lag1", bus.cmd_ready, 0);
    @(posedge clk); #1;
    check("idle_rise_lag2", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("idle_started", bus.busy, 1);
    wait_idle("idle_timeout", 1000);
    end_checks("idle", 64, 1);

    // Reset during bit 10 of a write data word
    reset_counts();
    exp_word.push_back(32'h20040002);
    wr_q.push_back(32'h11111111); wr_q.push_back(32'h22222222);
    start_txn(1'b0, 4'd4, 16'h0080, 11'd2);
    t = 0;
    while (!(c_words == 1 && c_bits == 10) && t < 500) begin @(posedge clk); #1; t++; end
    if (!(c_words == 1 && c_bits == 10)) fail_now("abort_reach_bit10");
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_sck", SCK, 0);
    check("abort_mosi", MOSI, 0);
    check("abort_busy", bus.busy, 0);
    rst = 1'b0;
    client_rst = 1'b1;
    wr_q.delete();
    sck_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      client_rst = 1'b0;
      if (SCK) sck_hi++;
    end
    check("abort_no_edges", sck_hi, 0);
    check("abort_no_done", dones, 0);
    check("abort_pending", exp_word.size(), 0);

    reset_counts();
    exp_word.push_back(32'hA8010001);
    exp_rd.push_back(32'hA5A5A585);
    start_txn(1'b1, 4'd5, 16'h0020, 11'd1);
    wait_idle("post_abort_timeout", 1000);
    end_checks("post_abort", 64, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
